// File: rtl/cache_refill_engine_if.sv
// AXI master-side bundle for the refill engine: AW/W/B write path and AR/R read path.
// No storage; purely wiring between the engine and the AXI slave.
// Backpressure is carried by the standard valid/ready pairs of each channel.
interface cache_refill_engine_if;
   // Read address channel
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   // Read data channel
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic        rlast;
   // Write address channel
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   // Write data channel
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic        wlast;
   // Write response channel
   logic        bvalid;
   logic        bready;

   modport master (
      output arvalid, araddr, arlen, rready,
      output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
      input  arready, rvalid, rdata, rlast,
      input  awready, wready, bvalid
   );

   modport slave (
      input  arvalid, araddr, arlen, rready,
      input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
      output arready, rvalid, rdata, rlast,
      output awready, wready, bvalid
   );
endinterface

// File: rtl/cache_refill_engine.sv
// Cache miss handler: optional dirty-victim writeback burst, then a line refill burst.
// Clean miss with a zero-wait slave: arvalid one cycle after miss_req, done 18 cycles after.
// Each AXI channel stalls on its ready/valid; writeback runs at one word per two cycles.
module cache_refill_engine #(
   parameter int CACHE_LINE_WIDTH = 6,
   parameter int TAG_WIDTH        = 20,
   parameter int OFFSET_WIDTH     = CACHE_LINE_WIDTH - 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // Cache controller side
   input  logic                    miss_req,
   input  logic [31:0]             miss_addr,
   input  logic                    victim_dirty,
   input  logic [31:0]             victim_addr,
   output logic                    busy,
   output logic                    done,
   // Line storage write port
   output logic                    line_we,
   output logic [TAG_WIDTH-1:0]    line_wtag,
   output logic [OFFSET_WIDTH-1:0] line_woff,
   output logic [31:0]             line_wdata,
   output logic [3:0]              line_wbe,
   output logic                    line_wdirty,
   output logic                    line_wvalid,
   // Line storage read port (registered, one cycle latency)
   output logic [OFFSET_WIDTH-1:0] line_roff,
   input  logic [31:0]             line_rdata,
   // AXI master port
   cache_refill_engine_if.master   axi
);

   localparam int LINE_ADDR_W = 32 - CACHE_LINE_WIDTH;
   localparam logic [7:0] BURST_LEN = 8'((1 << OFFSET_WIDTH) - 1);
   localparam logic [OFFSET_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB_AW,
      S_WB_FETCH,
      S_WB_DATA,
      S_WB_RESP,
      S_RF_AR,
      S_RF_DATA,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
   logic [LINE_ADDR_W-1:0]  miss_line_q, miss_line_d;
   logic [LINE_ADDR_W-1:0]  victim_line_q, victim_line_d;

   // Byte-within-line address bits never leave the engine; bursts are line aligned.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{miss_addr[CACHE_LINE_WIDTH-1:0], victim_addr[CACHE_LINE_WIDTH-1:0]};

   // Local copies of the AXI outputs, driven by the FSM and forwarded to the interface.
   logic        arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o;
   logic [31:0] wdata_o;

   // State, beat counter and latched line addresses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         miss_line_q   <= '0;
         victim_line_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         miss_line_q   <= miss_line_d;
         victim_line_q <= victim_line_d;
      end
   end

   // Next-state and per-state outputs; everything defaults to idle/zero first.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      miss_line_d   = miss_line_q;
      victim_line_d = victim_line_q;

      done        = 1'b0;
      line_we     = 1'b0;
      line_wdata  = '0;
      line_wbe    = 4'h0;
      line_wvalid = 1'b0;
      arvalid_o   = 1'b0;
      rready_o    = 1'b0;
      awvalid_o   = 1'b0;
      wvalid_o    = 1'b0;
      wdata_o     = '0;
      wlast_o     = 1'b0;
      bready_o    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
               miss_line_d   = miss_addr[31:CACHE_LINE_WIDTH];
               victim_line_d = victim_addr[31:CACHE_LINE_WIDTH];
               state_d       = victim_dirty ? S_WB_AW : S_RF_AR;
            end
         end

         S_WB_AW: begin
            awvalid_o = 1'b1;
            if (axi.awready) begin
               cnt_d   = '0;
               state_d = S_WB_FETCH;
            end
         end

         // One cycle for the registered line read to return the word at cnt.
         S_WB_FETCH: begin
            state_d = S_WB_DATA;
         end

         // line_roff stays at cnt, so line_rdata (and hence wdata) holds while stalled.
         S_WB_DATA: begin
            wvalid_o = 1'b1;
            wdata_o  = line_rdata;
            wlast_o  = (cnt_q == CNT_MAX);
            if (axi.wready) begin
               if (cnt_q == CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = S_WB_RESP;
               end else begin
                  cnt_d   = cnt_q + OFFSET_WIDTH'(1);
                  state_d = S_WB_FETCH;
               end
            end
         end

         // Response code is not inspected; a failed writeback is not recoverable here.
         S_WB_RESP: begin
            bready_o = 1'b1;
            if (axi.bvalid) begin
               state_d = S_RF_AR;
            end
         end

         S_RF_AR: begin
            arvalid_o = 1'b1;
            if (axi.arready) begin
               cnt_d   = '0;
               state_d = S_RF_DATA;
            end
         end

         // Each beat lands in the line the same cycle; valid is set only by the last beat,
         // so a partially refilled line never looks usable. rlast alone ends the burst.
         S_RF_DATA: begin
            rready_o = 1'b1;
            if (axi.rvalid) begin
               line_we     = 1'b1;
               line_wdata  = axi.rdata;
               line_wbe    = 4'hF;
               line_wvalid = axi.rlast;
               cnt_d       = cnt_q + OFFSET_WIDTH'(1);
               if (axi.rlast) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign line_wtag   = miss_line_q[LINE_ADDR_W-1 -: TAG_WIDTH];
   assign line_woff   = cnt_q;
   assign line_roff   = cnt_q;
   assign line_wdirty = 1'b0;

   assign axi.arvalid = arvalid_o;
   assign axi.araddr  = {miss_line_q, {CACHE_LINE_WIDTH{1'b0}}};
   assign axi.arlen   = BURST_LEN;
   assign axi.rready  = rready_o;
   assign axi.awvalid = awvalid_o;
   assign axi.awaddr  = {victim_line_q, {CACHE_LINE_WIDTH{1'b0}}};
   assign axi.awlen   = BURST_LEN;
   assign axi.wvalid  = wvalid_o;
   assign axi.wdata   = wdata_o;
   assign axi.wlast   = wlast_o;
   assign axi.bready  = bready_o;

endmodule
